// File: rtl/shift_sched_ctrl_if.sv
// Job, word-load, word-store and hash-core signals of the job-sequencing
// controller, bundled so the controller and its environment share one bus.
interface shift_sched_ctrl_if #(
   parameter int NONCE_W = 32
);
   // job control
   logic               job_start;
   logic               abort;
   logic [NONCE_W-1:0] nonce_base;

   // upstream word stream
   logic               word_valid;
   logic [31:0]        word_data;
   logic               word_ready;

   // word-store write port
   logic               wr_en;
   logic [4:0]         wr_addr;
   logic [31:0]        wr_data;

   // hash-core request/response
   logic               hash_start;
   logic [NONCE_W-1:0] hash_nonce;
   logic               hash_done;
   logic               hash_hit;

   // status
   logic               found;
   logic [NONCE_W-1:0] found_nonce;
   logic               exhausted;
   logic               busy;
   logic [2:0]         ctrl_state;

   // environment side: issues jobs, supplies words, returns hash results
   modport master (
      output job_start, abort, nonce_base,
      output word_valid, word_data,
      output hash_done, hash_hit,
      input  word_ready,
      input  wr_en, wr_addr, wr_data,
      input  hash_start, hash_nonce,
      input  found, found_nonce, exhausted, busy, ctrl_state
   );

   // controller side
   modport slave (
      input  job_start, abort, nonce_base,
      input  word_valid, word_data,
      input  hash_done, hash_hit,
      output word_ready,
      output wr_en, wr_addr, wr_data,
      output hash_start, hash_nonce,
      output found, found_nonce, exhausted, busy, ctrl_state
   );
endinterface

// File: rtl/shift_sched_ctrl.sv
// Job-sequencing controller: loads midstate and remaining-header words into
// the word store, then sweeps nonces through the hash core one request at a
// time until a hit or until the nonce space is exhausted.
module shift_sched_ctrl #(
   parameter int MID_WORDS = 8,
   parameter int REM_WORDS = 16,
   parameter int NONCE_W   = 32
) (
   input logic               clk,
   input logic               rst,
   shift_sched_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE      = 3'b000,
      LOAD_MID  = 3'b001,
      LOAD_REM  = 3'b010,
      HASH      = 3'b011,
      WAIT      = 3'b100,
      FOUND     = 3'b101,
      EXHAUSTED = 3'b110
   } state_t;

   localparam logic [4:0] LAST_MID = 5'(MID_WORDS - 1);
   localparam logic [4:0] LAST_REM = 5'(MID_WORDS + REM_WORDS - 1);

   state_t             state;
   state_t             state_nxt;

   logic [4:0]         widx;
   logic [NONCE_W-1:0] nonce;
   logic               found_q;
   logic [NONCE_W-1:0] found_nonce_q;
   logic               exhausted_q;
   logic               wr_en_q;
   logic [4:0]         wr_addr_q;
   logic [31:0]        wr_data_q;

   logic               loading;
   logic               beat;
   logic               start_job;
   logic               nonce_inc;
   logic               hit_latch;
   logic               exh_set;
   logic               hash_start_c;
   logic               busy_c;

   assign loading = (state == LOAD_MID) || (state == LOAD_REM);
   assign beat    = bus.word_valid && loading;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode and per-state control strobes; abort overrides all
   always_comb begin
      state_nxt    = state;
      start_job    = 1'b0;
      nonce_inc    = 1'b0;
      hit_latch    = 1'b0;
      exh_set      = 1'b0;
      hash_start_c = 1'b0;
      busy_c       = 1'b0;

      case (state)
         IDLE: begin
            if (bus.job_start) begin
               state_nxt = LOAD_MID;
               start_job = 1'b1;
            end
         end
         LOAD_MID: begin
            busy_c = 1'b1;
            if (beat && (widx == LAST_MID)) begin
               state_nxt = LOAD_REM;
            end
         end
         LOAD_REM: begin
            busy_c = 1'b1;
            if (beat && (widx == LAST_REM)) begin
               state_nxt = HASH;
            end
         end
         HASH: begin
            busy_c       = 1'b1;
            hash_start_c = 1'b1;
            state_nxt    = WAIT;
         end
         WAIT: begin
            busy_c = 1'b1;
            if (bus.hash_done) begin
               if (bus.hash_hit) begin
                  state_nxt = FOUND;
                  hit_latch = 1'b1;
               end else if (&nonce) begin
                  state_nxt = EXHAUSTED;
                  exh_set   = 1'b1;
               end else begin
                  state_nxt = HASH;
                  nonce_inc = 1'b1;
               end
            end
         end
         FOUND, EXHAUSTED: begin
            if (bus.job_start) begin
               state_nxt = LOAD_MID;
               start_job = 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      if (bus.abort) begin
         state_nxt = IDLE;
         start_job = 1'b0;
         nonce_inc = 1'b0;
         hit_latch = 1'b0;
         exh_set   = 1'b0;
      end
   end

   // Word counter and registered word-store write port; a beat coinciding
   // with abort still advances widx, which is harmless because widx is
   // cleared on the next job entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         widx      <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         wr_en_q <= beat && !bus.abort;
         if (beat && !bus.abort) begin
            wr_addr_q <= widx;
            wr_data_q <= bus.word_data;
         end
         if (start_job) begin
            widx <= '0;
         end else if (beat) begin
            widx <= widx + 5'd1;
         end
      end
   end

   // Nonce sweep register and result status flags
   always_ff @(posedge clk) begin
      if (rst) begin
         nonce         <= '0;
         found_q       <= 1'b0;
         found_nonce_q <= '0;
         exhausted_q   <= 1'b0;
      end else begin
         if (start_job) begin
            nonce         <= bus.nonce_base;
            found_q       <= 1'b0;
            found_nonce_q <= '0;
            exhausted_q   <= 1'b0;
         end
         if (nonce_inc) begin
            nonce <= nonce + NONCE_W'(1);
         end
         if (hit_latch) begin
            found_q       <= 1'b1;
            found_nonce_q <= nonce;
         end
         if (exh_set) begin
            exhausted_q <= 1'b1;
         end
         if (bus.abort) begin
            found_q       <= 1'b0;
            found_nonce_q <= '0;
            exhausted_q   <= 1'b0;
         end
      end
   end

   assign bus.word_ready  = loading;
   assign bus.wr_en       = wr_en_q;
   assign bus.wr_addr     = wr_addr_q;
   assign bus.wr_data     = wr_data_q;
   assign bus.hash_start  = hash_start_c;
   assign bus.hash_nonce  = nonce;
   assign bus.found       = found_q;
   assign bus.found_nonce = found_nonce_q;
   assign bus.exhausted   = exhausted_q;
   assign bus.busy        = busy_c;
   assign bus.ctrl_state  = state;

endmodule

// File: doc/shift_sched_ctrl.md
# shift_sched_ctrl

Job-sequencing controller for the mining datapath. It accepts a new job, streams the 8 midstate words and 16 remaining-header words into the word store via a valid/ready handshake, and then sweeps nonces through the hash core one request at a time. It reports either the first winning nonce or nonce-space exhaustion. Its 3-bit state output drives the shift timer and hash-core muxing.

## Interface
- MID_WORDS, 8, midstate words per job
- REM_WORDS, 16, remaining-header words per job (total words MID_WORDS+REM_WORDS ≤ 32)
- NONCE_W, 32, nonce width
- clk  in  1  single clock; all logic rising-edge
- rst  in  1  reset: synchronous, active-high
- job_start  in  1  pulse; begin new job (nonce_base sampled same cycle)
- abort  in  1  force return to IDLE
- nonce_base  in  NONCE_W  first nonce of the sweep
- word_valid  in  1  upstream word available
- word_data  in  32  upstream word
- word_ready  out  1  controller accepts a word this cycle
- wr_en  out  1  word-store write strobe
- wr_addr  out  5  word-store address
- wr_data  out  32  word-store data
- hash_start  out  1  one-cycle request to hash core
- hash_nonce  out  NONCE_W  nonce for the current request
- hash_done  in  1  hash core result valid (one-cycle pulse)
- hash_hit  in  1  result meets target; qualified by hash_done
- found  out  1  winning nonce latched
- found_nonce  out  NONCE_W  winning nonce
- exhausted  out  1  sweep finished with no hit
- busy  out  1  state is neither IDLE, FOUND nor EXHAUSTED
- ctrl_state  out  3  current state encoding

## Operation
- States and encodings: IDLE=000, LOAD_MID=001, LOAD_REM=010, HASH=011, WAIT=100, FOUND=101, EXHAUSTED=110. The value 111 is unreachable; if it is ever decoded, the next state is IDLE.
- Accepted beat: word_valid && word_ready. word_ready = 1 only in LOAD_MID and LOAD_REM.
- An internal 5-bit word counter widx is cleared on job entry and incremented on each accepted beat.
- IDLE: job_start → LOAD_MID. widx ← 0, nonce ← nonce_base, found ← 0, exhausted ← 0.
- LOAD_MID: an accepted beat with widx == MID_WORDS-1 → LOAD_REM.
- LOAD_REM: an accepted beat with widx == MID_WORDS+REM_WORDS-1 → HASH.
- Each accepted beat writes word_data to store address widx.
- HASH: hash_start = 1 for exactly this cycle; hash_nonce = nonce. Next state is always WAIT.
- WAIT: hash_nonce is held.
  - hash_done && hash_hit → FOUND, with found_nonce ← nonce.
  - hash_done && !hash_hit && nonce == all-ones → EXHAUSTED.
  - hash_done otherwise → HASH, with nonce ← nonce+1.
- Nonce arithmetic is modulo 2^NONCE_W, but the all-ones check prevents wrap.
- FOUND / EXHAUSTED: status is held. job_start restarts the job exactly as from IDLE. Otherwise the state holds.
- job_start in LOAD_MID, LOAD_REM, HASH or WAIT is ignored.
- abort in any state → IDLE next cycle. found, exhausted and found_nonce are cleared, and no store write is issued for a beat in the abort cycle.
- abort has priority over job_start and hash_done. rst has priority over everything.
- hash_done is ignored in every state except WAIT.

## Timing
- Reset values: ctrl_state 000, word_ready 0, wr_en 0, wr_addr 0, wr_data 0, hash_start 0, hash_nonce 0, found 0, found_nonce 0, exhausted 0, busy 0.
- State and flag outputs are registered (Moore). word_ready, hash_start, busy and ctrl_state decode the current state only.
- Store write: wr_en/wr_addr/wr_data are registered, so they appear the cycle after the accepted beat and are high for 1 cycle per beat.
- Back-to-back beats (one every cycle) are supported.
- Latencies:
  - job_start → word_ready high: 1 cycle.
  - Last word beat → hash_start: 1 cycle.
  - hash_done (miss) → next hash_start: 1 cycle.
  - hash_done (hit) → found high: 1 cycle.
- Minimum nonce period is 2 cycles (HASH + WAIT with immediate hash_done).
- found_nonce is stable from the cycle found rises until restart, abort or rst.

## Test plan
- Reset then idle: rst for 2 cycles, word_valid = 1 held → all outputs at reset values, no wr_en, ctrl_state 000.
- Full load: job_start, nonce_base = 0x10, then 24 back-to-back words 0xA0..0xB7 →
  - wr_addr 0..23 with matching data, each 1 cycle after its beat;
  - ctrl_state 001 for 8 beats, then 010 for 16 beats;
  - hash_start with hash_nonce = 0x10 one cycle after the 24th beat.
- Load with gaps: word_valid toggled randomly → writes occur only on accepted beats, addresses stay contiguous, and the final transition happens only on the 24th beat.
- Sweep and hit: core returns a miss for 3 requests, then a hit on the 4th, nonce_base = 0x10 → hash_nonce sequence is 0x10, 0x11, 0x12, 0x13; then found = 1, found_nonce = 0x13, busy = 0.
- Exhaustion: nonce_base = 0xFFFFFFFE, two misses → EXHAUSTED (110), exhausted = 1, no third hash_start; a following job_start restarts at LOAD_MID with exhausted cleared.
- Simultaneous events: abort together with hash_done && hash_hit in WAIT → IDLE, found stays 0. Also, abort asserted mid-load on the 5th beat → no write for that beat, ctrl_state 000 next cycle, and a new job restarts at wr_addr 0.
